// File: rtl/add_mul_sgn_seq.sv
// Sequential signed (XS+XC)*Y multiply-accumulate. Retires step_bits multiplier bits per cycle
// into a one-bit-guarded partial sum, with sticky overflow across accumulating ops.
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | waiting for operands, in_ready=1
// BUSY  | retiring one multiplier digit per cycle, cnt = 0..n_steps-1
// DONE  | p/ovf hold a fresh result, out_valid=1 until out_ready
module add_mul_sgn_seq #(
  parameter int width_x   = 8,
  parameter int width_y   = 8,
  parameter int step_bits = 1,
  parameter int width_a   = 20
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic signed [width_x-1:0] xs,
  input  logic signed [width_x-1:0] xc,
  input  logic signed [width_y-1:0] y,
  input  logic                      acc,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic signed [width_a-1:0] p,
  output logic                      ovf
);

  localparam int n_steps = (width_x + step_bits) / step_bits;
  localparam int xw      = n_steps * step_bits;
  localparam int gw      = width_a + 1;
  localparam int cw      = (n_steps > 1) ? $clog2(n_steps) : 1;

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

  state_t                 state, state_nxt;
  logic [cw-1:0]          cnt;
  logic                   last_step, accept, step_en, acc_q;
  logic signed [width_x:0] x_sum;
  logic signed [xw-1:0]   x_sh;
  logic [step_bits-1:0]   dig;
  logic signed [gw-1:0]   y_sh, part, dig_ext, term, fin, base;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    step_en   = 1'b0;
    case (state)
      S_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nxt = S_BUSY;
      end
      S_BUSY: begin
        step_en = 1'b1;
        if (last_step) state_nxt = S_DONE;
      end
      S_DONE: begin
        out_valid = 1'b1;
        in_ready  = out_ready;
        if (out_ready) state_nxt = in_valid ? S_BUSY : S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  assign accept    = in_valid & in_ready;
  assign last_step = (cnt == cw'(n_steps - 1));

  // Exact carry-save sum: one extra bit removes any overflow restriction on XS+XC.
  assign x_sum = $signed({xs[width_x-1], xs}) + $signed({xc[width_x-1], xc});
  assign dig   = x_sh[step_bits-1:0];

  // The top digit is two's complement (its MSB has negative weight), lower digits are unsigned.
  assign dig_ext = last_step ? gw'($signed(dig)) : gw'(dig);
  assign term    = dig_ext * y_sh;
  assign fin     = part + term;
  assign base    = acc ? gw'(p) : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_sh  <= '0;
      y_sh  <= '0;
      part  <= '0;
      cnt   <= '0;
      acc_q <= 1'b0;
      p     <= '0;
      ovf   <= 1'b0;
    end else if (accept) begin
      x_sh  <= xw'(x_sum);
      y_sh  <= gw'(y);
      part  <= base;
      cnt   <= '0;
      acc_q <= acc;
      if (!acc) ovf <= 1'b0;
    end else if (step_en) begin
      x_sh <= x_sh >> step_bits;
      y_sh <= y_sh << step_bits;
      part <= fin;
      cnt  <= cnt + cw'(1);
      if (last_step) begin
        p   <= fin[width_a-1:0];
        ovf <= (acc_q & ovf) | (fin[gw-1] ^ fin[gw-2]);
      end
    end
  end

endmodule

// File: tb/tb_add_mul_sgn_seq.sv
// Directed bench for add_mul_sgn_seq: default instance (N=9) and a step_bits=4 instance (N=3).
module tb_add_mul_sgn_seq;

  logic clk = 1'b0;
  logic rst_n;

  logic              iv, ir, ac, ov, ordy, ovf;
  logic signed [7:0] xs, xc, y;
  logic signed [19:0] p;

  logic              iv4, ir4, ac4, ov4, ordy4, ovf4;
  logic signed [7:0] xs4, xc4, y4;
  logic signed [19:0] p4;

  int n_checks = 0;
  int n_fail   = 0;
  int lat;

  always #5 clk = ~clk;

  add_mul_sgn_seq dut (
    .clk(clk), .rst_n(rst_n), .in_valid(iv), .in_ready(ir),
    .xs(xs), .xc(xc), .y(y), .acc(ac),
    .out_valid(ov), .out_ready(ordy), .p(p), .ovf(ovf)
  );

  add_mul_sgn_seq #(.width_x(8), .width_y(8), .step_bits(4), .width_a(20)) dut4 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv4), .in_ready(ir4),
    .xs(xs4), .xc(xc4), .y(y4), .acc(ac4),
    .out_valid(ov4), .out_ready(ordy4), .p(p4), .ovf(ovf4)
  );

  task automatic check_val(input string tag, input logic signed [31:0] got,
                           input logic signed [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  // Issue one op with the consumer always ready; returns cycles from accept edge to out_valid.
  task automatic do_op(input bit u4, input int a, input int b, input int c, input bit acc_in,
                       output int lat_o);
    int w;
    @(negedge clk);
    if (u4) begin xs4 = 8'(a); xc4 = 8'(b); y4 = 8'(c); ac4 = acc_in; iv4 = 1'b1; ordy4 = 1'b1; end
    else    begin xs  = 8'(a); xc  = 8'(b); y  = 8'(c); ac  = acc_in; iv  = 1'b1; ordy  = 1'b1; end
    w = 0;
    while (!(u4 ? ir4 : ir) && w < 20) begin @(negedge clk); w++; end
    @(posedge clk);
    @(negedge clk);
    // Scramble operands after accept: the block must not need them held.
    if (u4) begin iv4 = 1'b0; xs4 = 8'h5a; xc4 = 8'ha5; y4 = 8'h33; ac4 = 1'b1; end
    else    begin iv  = 1'b0; xs  = 8'h5a; xc  = 8'ha5; y  = 8'h33; ac  = 1'b1; end
    lat_o = 0;
    while (!(u4 ? ov4 : ov) && lat_o < 50) begin
      @(posedge clk); lat_o++; @(negedge clk);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    iv = 0; ac = 0; ordy = 1; xs = 0; xc = 0; y = 0;
    iv4 = 0; ac4 = 0; ordy4 = 1; xs4 = 0; xc4 = 0; y4 = 0;
    #1;
    check_val("rst_p", p, 0);
    check_val("rst_ovf", ovf, 0);
    check_val("rst_out_valid", ov, 0);
    check_val("rst_in_ready", ir, 1);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    do_op(0, 100, 100, -3, 0, lat);
    check_val("x200_p", p, -600);
    check_val("x200_ovf", ovf, 0);
    check_val("x200_lat", lat, 9);

    do_op(0, -128, -128, -128, 0, lat);
    check_val("neg_p", p, 32768);
    check_val("neg_ovf", ovf, 0);

    do_op(0, 127, 127, 127, 0, lat);
    check_val("acc0_p", p, 32258);
    for (int i = 1; i <= 16; i++) begin
      do_op(0, 127, 127, 127, 1, lat);
      if (i == 15) begin
        check_val("acc15_p", p, 516128);
        check_val("acc15_ovf", ovf, 0);
      end
    end
    check_val("acc16_p", p, -500190);
    check_val("acc16_ovf", ovf, 1);
    do_op(0, 5, 9, 0, 0, lat);
    check_val("clr_p", p, 0);
    check_val("clr_ovf", ovf, 0);

    // Back-pressure then simultaneous handoff/accept
    @(negedge clk);
    xs = 10; xc = 5; y = 7; ac = 0; iv = 1; ordy = 0;
    @(posedge clk);
    @(negedge clk);
    iv = 0;
    lat = 0;
    while (!ov && lat < 50) begin @(posedge clk); lat++; @(negedge clk); end
    check_val("bp_lat", lat, 9);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check_val("bp_hold_p", p, 105);
      check_val("bp_hold_valid", ov, 1);
      check_val("bp_hold_in_ready", ir, 0);
      check_val("bp_hold_ovf", ovf, 0);
    end
    xs = 1; xc = 1; y = 3; ac = 1; iv = 1; ordy = 1;
    #1;
    check_val("bp_in_ready", ir, 1);
    @(posedge clk);
    @(negedge clk);
    iv = 0;
    check_val("bp_accepted", ov, 0);
    lat = 0;
    while (!ov && lat < 50) begin @(posedge clk); lat++; @(negedge clk); end
    check_val("bp2_lat", lat, 9);
    check_val("bp2_p", p, 111);

    // Reset in the middle of BUSY (counter at 4)
    @(negedge clk);
    xs = 20; xc = 20; y = 20; ac = 0; iv = 1;
    @(posedge clk);
    @(negedge clk);
    iv = 0;
    repeat (4) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check_val("mid_rst_p", p, 0);
    check_val("mid_rst_valid", ov, 0);
    check_val("mid_rst_in_ready", ir, 1);
    @(negedge clk);
    rst_n = 1'b1;
    do_op(0, 3, 4, -5, 0, lat);
    check_val("post_rst_p", p, -35);
    check_val("post_rst_lat", lat, 9);

    // step_bits=4 instance
    do_op(1, -1, 0, -1, 0, lat);
    check_val("s4_a_p", p4, 1);
    check_val("s4_a_lat", lat, 3);
    do_op(1, 127, 1, -128, 0, lat);
    check_val("s4_b_p", p4, -16384);
    check_val("s4_b_ovf", ovf4, 0);
    check_val("s4_b_lat", lat, 3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
